trap_ctrl: RTL and testbench

Machine-mode trap controller.
- Consumes exception reports (exc_en/exc_code/exc_val) raised by the PC and fetch/decode stages, plus one external interrupt line.
- Captures the trap CSRs and drives the PC redirect inputs: pc_trap_taken/pc_trap on trap entry, pc_ret_taken/pc_ret on mret.
- Holds the mstatus/mie/mtvec/mepc/mcause/mtval/mip CSRs and exposes a single-cycle CSR read/write port.

---
 rtl/trap_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap controller: trap CSRs, trap entry/mret sequencing, PC redirect
module trap_ctrl #(
    parameter logic [63:0] MTVEC_RESET = 64'h100,
    parameter logic        VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_en,
    input  logic [3:0]  exc_code,
    input  logic [63:0] exc_val,
    input  logic [63:0] cur_pc,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        pc_en,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic        pc_trap_taken,
    output logic [63:0] pc_trap,
    output logic        pc_ret_taken,
    output logic [63:0] pc_ret,
    output logic        trap_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TRAP = 2'd1;
    localparam logic [1:0] ST_RET  = 2'd2;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    // Mode bit 0 only survives when vectored interrupts are supported.
    localparam logic [63:0] MTVEC_MASK = VECTORED_EN ? ~64'h2 : ~64'h3;
    localparam logic [63:0] IRQ_CAUSE  = {1'b1, 63'd11};

    logic [1:0]  state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        meie_q, meie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d;
    logic [63:0] pc_trap_q, pc_trap_d;

    logic        irq_pending;
    logic [63:0] trap_base;

    assign irq_pending = mie_q & meie_q & irq_ext;
    assign trap_base   = {mtvec_q[63:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        mie_d     = mie_q;
        mpie_d    = mpie_q;
        meie_d    = meie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;
        pc_trap_d = pc_trap_q;

        if (csr_we) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                A_MIE:    meie_d   = csr_wdata[11];
                A_MTVEC:  mtvec_d  = csr_wdata & MTVEC_MASK;
                A_MEPC:   mepc_d   = {csr_wdata[63:2], 2'b00};
                A_MCAUSE: mcause_d = csr_wdata;
                A_MTVAL:  mtval_d  = csr_wdata;
                default:  ;
            endcase
        end

        // Trap/mret updates are applied after the CSR write so they win on shared fields.
        case (state_q)
            ST_IDLE: begin
                if (exc_en || irq_pending) begin
                    mepc_d  = {cur_pc[63:2], 2'b00};
                    mpie_d  = mie_q;
                    mie_d   = 1'b0;
                    state_d = ST_TRAP;
                    if (exc_en) begin
                        mcause_d  = {60'd0, exc_code};
                        mtval_d   = exc_val;
                        pc_trap_d = trap_base;
                    end else begin
                        mcause_d  = IRQ_CAUSE;
                        mtval_d   = 64'd0;
                        pc_trap_d = mtvec_q[0] ? trap_base + 64'd44 : trap_base;
                    end
                end else if (mret) begin
                    mie_d   = mpie_q;
                    mpie_d  = 1'b1;
                    state_d = ST_RET;
                end
            end
            ST_TRAP, ST_RET: begin
                if (pc_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            meie_q    <= 1'b0;
            mtvec_q   <= MTVEC_RESET & MTVEC_MASK;
            mepc_q    <= 64'd0;
            mcause_q  <= 64'd0;
            mtval_q   <= 64'd0;
            pc_trap_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            mie_q     <= mie_d;
            mpie_q    <= mpie_d;
            meie_q    <= meie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
            pc_trap_q <= pc_trap_d;
        end
    end

    always_comb begin
        csr_rdata = 64'd0;
        case (csr_addr)
            A_MSTATUS: csr_rdata = {56'd0, mpie_q, 3'd0, mie_q, 3'd0};
            A_MIE:     csr_rdata = {52'd0, meie_q, 11'd0};
            A_MTVEC:   csr_rdata = mtvec_q;
            A_MEPC:    csr_rdata = mepc_q;
            A_MCAUSE:  csr_rdata = mcause_q;
            A_MTVAL:   csr_rdata = mtval_q;
            A_MIP:     csr_rdata = {52'd0, irq_ext, 11'd0};
            default:   csr_rdata = 64'd0;
        endcase
    end

    assign pc_trap_taken = (state_q == ST_TRAP);
    assign pc_ret_taken  = (state_q == ST_RET);
    assign trap_busy     = (state_q != ST_IDLE);
    assign pc_trap       = pc_trap_q;
    assign pc_ret        = mepc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed and randomized checks of trap_ctrl against a behavioural model
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_en = 1'b0;
    logic [3:0]  exc_code = 4'd0;
    logic [63:0] exc_val = 64'd0;
    logic [63:0] cur_pc = 64'd0;
    logic        mret = 1'b0;
    logic        irq_ext = 1'b0;
    logic        pc_en = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [63:0] csr_wdata = 64'd0;
    logic [63:0] csr_rdata;
    logic        pc_trap_taken;
    logic [63:0] pc_trap;
    logic        pc_ret_taken;
    logic [63:0] pc_ret;
    logic        trap_busy;

    always #10 clk = ~clk;

    trap_ctrl #(.MTVEC_RESET(64'h100), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .exc_en(exc_en), .exc_code(exc_code),
        .exc_val(exc_val), .cur_pc(cur_pc), .mret(mret), .irq_ext(irq_ext),
        .pc_en(pc_en), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .pc_trap_taken(pc_trap_taken), .pc_trap(pc_trap),
        .pc_ret_taken(pc_ret_taken), .pc_ret(pc_ret), .trap_busy(trap_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 = idle, 1 = redirecting to trap, 2 = redirecting to mepc
    int          m_mode;
    logic        m_mie, m_mpie, m_meie;
    logic [63:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_pctrap;
    bit          m_valid = 0;

    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'h345};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'(m_mie) * 8 + 64'(m_mpie) * 128;
            12'h304: return 64'(m_meie) * 2048;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return 64'(irq_ext) * 2048;
            default: return 64'd0;
        endcase
    endfunction

    task automatic step();
        int          n_mode;
        logic        n_mie, n_mpie, n_meie;
        logic [63:0] n_mtvec, n_mepc, n_mcause, n_mtval, n_pctrap;
        @(negedge clk);
        if (m_valid) begin
            check("pc_trap_taken", 64'(pc_trap_taken), 64'(m_mode == 1));
            check("pc_ret_taken", 64'(pc_ret_taken), 64'(m_mode == 2));
            check("trap_busy", 64'(trap_busy), 64'(m_mode != 0));
            check("pc_trap", pc_trap, m_pctrap);
            check("pc_ret", pc_ret, m_mepc);
            check("csr_rdata", csr_rdata, model_read(csr_addr));
        end
        n_mode = m_mode; n_mie = m_mie; n_mpie = m_mpie; n_meie = m_meie;
        n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
        n_mtval = m_mtval; n_pctrap = m_pctrap;
        if (csr_we) begin
            case (csr_addr)
                12'h300: begin n_mie = csr_wdata[3]; n_mpie = csr_wdata[7]; end
                12'h304: n_meie = csr_wdata[11];
                12'h305: n_mtvec = csr_wdata & ~64'h2;
                12'h341: n_mepc = csr_wdata & ~64'h3;
                12'h342: n_mcause = csr_wdata;
                12'h343: n_mtval = csr_wdata;
                default: ;
            endcase
        end
        if (rst) begin
            n_mode = 0; n_mie = 0; n_mpie = 0; n_meie = 0; n_mtvec = 64'h100;
            n_mepc = 0; n_mcause = 0; n_mtval = 0; n_pctrap = 0;
        end else if (m_mode == 0) begin
            if (exc_en || (m_mie && m_meie && irq_ext)) begin
                n_mode = 1;
                n_mepc = cur_pc & ~64'h3;
                n_mpie = m_mie;
                n_mie = 0;
                if (exc_en) begin
                    n_mcause = 64'(exc_code);
                    n_mtval = exc_val;
                    n_pctrap = m_mtvec & ~64'h3;
                end else begin
                    n_mcause = 64'h8000_0000_0000_000B;
                    n_mtval = 0;
                    n_pctrap = (m_mtvec & ~64'h3) + (m_mtvec[0] ? 64'd44 : 64'd0);
                end
            end else if (mret) begin
                n_mode = 2;
                n_mie = m_mpie;
                n_mpie = 1;
            end
        end else if (pc_en) begin
            n_mode = 0;
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_mie = n_mie; m_mpie = n_mpie; m_meie = n_meie;
        m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
        m_mtval = n_mtval; m_pctrap = n_pctrap;
        m_valid = 1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
        csr_we = 1'b0;
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_taken", 64'(pc_trap_taken), 64'd0);
        check("rst_ret", 64'(pc_ret_taken), 64'd0);
        check("rst_busy", 64'(trap_busy), 64'd0);
        rd("rst_mtvec", 12'h305, 64'h100);
        rd("rst_mstatus", 12'h300, 64'd0);
        rd("rst_mepc", 12'h341, 64'd0);
        rd("rst_mcause", 12'h342, 64'd0);

        // Misaligned fetch with immediate acknowledge
        exc_en = 1; exc_code = 4'd0; exc_val = 64'h1002; cur_pc = 64'h1000; pc_en = 1;
        step();
        exc_en = 0;
        #1;
        check("t2_taken", 64'(pc_trap_taken), 64'd1);
        check("t2_pc_trap", pc_trap, 64'h100);
        rd("t2_mepc", 12'h341, 64'h1000);
        rd("t2_mcause", 12'h342, 64'd0);
        rd("t2_mtval", 12'h343, 64'h1002);
        step();
        #1;
        check("t2_idle", 64'(trap_busy), 64'd0);

        // Redirect held until pc_en; second exception ignored
        exc_en = 1; exc_code = 4'd0; pc_en = 0;
        step();
        exc_code = 4'd2;
        step();
        exc_en = 0;
        step();
        #1;
        check("t3_hold", 64'(pc_trap_taken), 64'd1);
        rd("t3_mcause", 12'h342, 64'd0);
        pc_en = 1;
        step();
        #1;
        check("t3_release", 64'(pc_trap_taken), 64'd0);

        // Vectored interrupt
        wr(12'h305, 64'h201);
        wr(12'h300, 64'h8);
        wr(12'h304, 64'h800);
        irq_ext = 1; cur_pc = 64'h3004; pc_en = 0;
        step();
        irq_ext = 0;
        #1;
        check("t4_pc_trap", pc_trap, 64'h22C);
        rd("t4_mcause", 12'h342, 64'h8000_0000_0000_000B);
        rd("t4_mtval", 12'h343, 64'd0);
        rd("t4_mstatus", 12'h300, 64'h80);
        pc_en = 1;
        step();

        // mret
        pc_en = 0; mret = 1;
        step();
        mret = 0;
        #1;
        check("t5_ret_taken", 64'(pc_ret_taken), 64'd1);
        check("t5_pc_ret", pc_ret, 64'h3004);
        pc_en = 1;
        step();
        rd("t5_mstatus", 12'h300, 64'h88);

        // Simultaneous exception, interrupt and mret; then reset during TRAP
        exc_en = 1; exc_code = 4'd5; exc_val = 64'h55; irq_ext = 1; mret = 1; pc_en = 0;
        step();
        exc_en = 0; irq_ext = 0; mret = 0;
        #1;
        check("t6_taken", 64'(pc_trap_taken), 64'd1);
        check("t6_no_ret", 64'(pc_ret_taken), 64'd0);
        rd("t6_mcause", 12'h342, 64'd5);
        rst = 1;
        step();
        rst = 0;
        #1;
        check("t6_rst_taken", 64'(pc_trap_taken), 64'd0);
        rd("t6_rst_mtvec", 12'h305, 64'h100);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(127) == 0);
            exc_en = ($urandom_range(7) == 0);
            exc_code = 4'($urandom_range(15));
            exc_val = {$urandom(), $urandom()};
            cur_pc = {$urandom(), $urandom()};
            mret = ($urandom_range(7) == 0);
            irq_ext = ($urandom_range(3) == 0);
            pc_en = ($urandom_range(1) == 0);
            csr_we = ($urandom_range(3) == 0);
            csr_addr = addrs[$urandom_range(7)];
            csr_wdata = {$urandom(), $urandom()};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
